// File: rtl/serial_adder_sipo_if.sv
// serial_adder_sipo_if
//   Bundles the serial operand stream and the parallel result of the
//   bit-serial adder.
//   master : drives start, cin, bit_valid, a_bit, b_bit; observes results.
//   slave  : the adder; receives the stream, drives sum, cout, sum_valid,
//            busy (and ovf when OVF_DETECT_EN is defined).
//   Optional macro: OVF_DETECT_EN adds the signed-overflow flag ovf.
interface serial_adder_sipo_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             cin;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             sum_valid;
  logic             busy;
`ifdef OVF_DETECT_EN
  logic             ovf;

  modport master (
    output start, cin, bit_valid, a_bit, b_bit,
    input  sum, cout, sum_valid, busy, ovf
  );
  modport slave (
    input  start, cin, bit_valid, a_bit, b_bit,
    output sum, cout, sum_valid, busy, ovf
  );
`else
  modport master (
    output start, cin, bit_valid, a_bit, b_bit,
    input  sum, cout, sum_valid, busy
  );
  modport slave (
    input  start, cin, bit_valid, a_bit, b_bit,
    output sum, cout, sum_valid, busy
  );
`endif
endinterface

// File: rtl/serial_adder_sipo.sv
// serial_adder_sipo
//   Bit-serial adder with a serial-in/parallel-out result register. Takes
//   one LSB-first bit of A and B per valid cycle, keeps the running carry in
//   a flop, and after WIDTH bits publishes {cout, sum} = A + B + cin with a
//   one-cycle sum_valid pulse. sum/cout hold until the next completed word.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-high reset
//     bus    : serial_adder_sipo_if.slave
//              in : start, cin, bit_valid, a_bit, b_bit
//              out: sum[WIDTH-1:0], cout, sum_valid, busy, ovf (optional)
//   Optional macro: OVF_DETECT_EN adds ovf = carry-into-MSB ^ carry-out,
//   registered alongside sum/cout.
//   WIDTH must be >= 2 and match the interface instance's WIDTH.
module serial_adder_sipo #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              reset,
  serial_adder_sipo_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             sum_valid_q, sum_valid_d;
`ifdef OVF_DETECT_EN
  logic             ovf_q, ovf_d;
`endif

  logic             s_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] shifted;

  // Full-adder slice for the current bit; the sum bit enters at the MSB so
  // that after WIDTH shifts the first (LSB) bit lands in bit 0.
  assign s_bit     = bus.a_bit ^ bus.b_bit ^ carry_q;
  assign carry_nxt = (bus.a_bit & bus.b_bit) | (carry_q & (bus.a_bit ^ bus.b_bit));
  assign shifted   = {s_bit, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      sum_valid_q <= 1'b0;
`ifdef OVF_DETECT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      sum_valid_q <= sum_valid_d;
`ifdef OVF_DETECT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    sum_valid_d = 1'b0;
`ifdef OVF_DETECT_EN
    ovf_d       = ovf_q;
`endif

    // start has priority over any bit in the same cycle, in either state;
    // a start during RUN abandons the word without a result.
    if (bus.start) begin
      state_d = RUN;
      carry_d = bus.cin;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (state_q == RUN && bus.bit_valid) begin
      carry_d = carry_nxt;
      shreg_d = shifted;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) begin
        state_d     = IDLE;
        cnt_d       = '0;
        sum_d       = shifted;
        cout_d      = carry_nxt;
        sum_valid_d = 1'b1;
`ifdef OVF_DETECT_EN
        // carry_q is the carry into the MSB while the last bit is processed.
        ovf_d       = carry_q ^ carry_nxt;
`endif
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.busy      = (state_q == RUN);
`ifdef OVF_DETECT_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_sipo.sv
// Testbench for serial_adder_sipo (optional macro OVF_DETECT_EN honoured).
module tb_serial_adder_sipo;

  localparam int W = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   sv_cnt;

  serial_adder_sipo_if #(.WIDTH(W)) bus ();

  serial_adder_sipo #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count result pulses away from the active edge.
  always @(negedge clk) if (bus.sum_valid === 1'b1) sv_cnt++;

  // Reference: {cout, sum} = A + B + cin.
  function automatic logic [W:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int r;
    logic [W:0] v;
    r = int'(a) + int'(b) + int'(c);
    v = r[W:0];
    return v;
  endfunction

  // Reference signed overflow: carry into MSB xor carry out of MSB.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c);
    int lo, full;
    lo   = (int'(a) % (2 ** (W - 1))) + (int'(b) % (2 ** (W - 1))) + int'(c);
    full = int'(a) + int'(b) + int'(c);
    return ((lo >> (W - 1)) & 1) != ((full >> W) & 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic c);
    bus.start = 1'b1;
    bus.cin = c;
    bus.bit_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.cin = 1'b0;
  endtask

  // Drives bits [from, from+n) of a/b; returns one cycle after the last bit.
  task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int from, input int n, input int gap);
    for (int i = from; i < from + n; i++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit = a[i];
      bus.b_bit = b[i];
      tick();
      bus.bit_valid = 1'b0;
      if (i < from + n - 1) for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_tests++;
    if ({bus.sum_valid, bus.busy, bus.cout, bus.sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sv=%b busy=%b cout=%b sum=%0d required all 0",
               bus.sum_valid, bus.busy, bus.cout, bus.sum);
    end
`ifdef OVF_DETECT_EN
    n_tests++;
    if (bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b required 0", bus.ovf);
    end
`endif
  endtask

  task automatic test_basic();
    logic [W-1:0] av [3] = '{4'd5, 4'd15, 4'd0};
    logic [W-1:0] bv [3] = '{4'd3, 4'd1, 4'd0};
    logic         cv [3] = '{1'b0, 1'b1, 1'b1};
    logic [W:0]   ev [3] = '{5'd8, 5'd17, 5'd1};
    for (int k = 0; k < 3; k++) begin
      do_start(cv[k]);
      send_bits(av[k], bv[k], 0, W, 0);
      n_tests++;
      if ({bus.sum_valid, bus.busy, bus.cout, bus.sum} !== {1'b1, 1'b0, ev[k]}) begin
        n_fail++;
        $display("FAIL basic_%0d: got sv=%b busy=%b cout=%b sum=%0d required sv=1 busy=0 {cout,sum}=%0d",
                 k, bus.sum_valid, bus.busy, bus.cout, bus.sum, ev[k]);
      end
      tick();
      n_tests++;
      if ({bus.sum_valid, bus.cout, bus.sum} !== {1'b0, ev[k]}) begin
        n_fail++;
        $display("FAIL basic_hold_%0d: got sv=%b cout=%b sum=%0d required sv=0 {cout,sum}=%0d",
                 k, bus.sum_valid, bus.cout, bus.sum, ev[k]);
      end
    end
  endtask

  task automatic test_gaps();
    int sv0;
    do_start(1'b0);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_busy_after_start: got %b required 1", bus.busy);
    end
    sv0 = sv_cnt;
    send_bits(4'd9, 4'd6, 0, W - 1, 2);
    tick();
    tick();
    n_tests++;
    if ({bus.busy, bus.sum_valid} !== 2'b10 || sv_cnt != sv0) begin
      n_fail++;
      $display("FAIL gaps_midword: got busy=%b sv=%b pulses=%0d required busy=1 sv=0 pulses=0",
               bus.busy, bus.sum_valid, sv_cnt - sv0);
    end
    send_bits(4'd9, 4'd6, W - 1, 1, 0);
    n_tests++;
    if ({bus.sum_valid, bus.cout, bus.sum} !== {1'b1, 5'd15}) begin
      n_fail++;
      $display("FAIL gaps_result: got sv=%b cout=%b sum=%0d required sv=1 cout=0 sum=15",
               bus.sum_valid, bus.cout, bus.sum);
    end
    tick();
    tick();
    n_tests++;
    if (sv_cnt - sv0 != 1) begin
      n_fail++;
      $display("FAIL gaps_pulse_count: got %0d required 1", sv_cnt - sv0);
    end
  endtask

  task automatic test_restart();
    int sv0;
    sv0 = sv_cnt;
    do_start(1'b1);
    send_bits(4'hF, 4'hF, 0, 2, 0);
    do_start(1'b0);
    send_bits(4'd2, 4'd2, 0, W, 0);
    tick();
    n_tests++;
    if ({bus.cout, bus.sum} !== 5'd4 || sv_cnt - sv0 != 1) begin
      n_fail++;
      $display("FAIL restart: got cout=%b sum=%0d pulses=%0d required cout=0 sum=4 pulses=1",
               bus.cout, bus.sum, sv_cnt - sv0);
    end
    // start coinciding with the last bit abandons the word.
    sv0 = sv_cnt;
    do_start(1'b0);
    send_bits(4'd7, 4'd7, 0, W - 1, 0);
    bus.start = 1'b1;
    bus.bit_valid = 1'b1;
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.bit_valid = 1'b0;
    tick();
    n_tests++;
    if (sv_cnt != sv0 || bus.busy !== 1'b1 || bus.sum !== 4'd4) begin
      n_fail++;
      $display("FAIL start_on_last_bit: got pulses=%0d busy=%b sum=%0d required 0 1 4",
               sv_cnt - sv0, bus.busy, bus.sum);
    end
    send_bits(4'd3, 4'd4, 0, W, 0);
    n_tests++;
    if ({bus.sum_valid, bus.cout, bus.sum} !== {1'b1, 5'd7}) begin
      n_fail++;
      $display("FAIL after_last_bit_restart: got sv=%b cout=%b sum=%0d required sv=1 sum=7",
               bus.sum_valid, bus.cout, bus.sum);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int sv0;
    sv0 = sv_cnt;
    do_start(1'b1);
    send_bits(4'hB, 4'h6, 0, 3, 0);
    bus.bit_valid = 1'b1;
    bus.a_bit = 1'b1;
    bus.b_bit = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.bit_valid = 1'b0;
    tick();
    tick();
    n_tests++;
    if (sv_cnt != sv0 || {bus.busy, bus.cout, bus.sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: got pulses=%0d busy=%b cout=%b sum=%0d required all 0",
               sv_cnt - sv0, bus.busy, bus.cout, bus.sum);
    end
  endtask

  task automatic test_start_collision();
    int sv0;
    bus.start = 1'b1;
    bus.cin = 1'b0;
    bus.bit_valid = 1'b1;
    bus.a_bit = 1'b1;
    bus.b_bit = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bit_valid = 1'b0;
    send_bits(4'd1, 4'd1, 0, W, 0);
    n_tests++;
    if ({bus.sum_valid, bus.cout, bus.sum} !== {1'b1, 5'd2}) begin
      n_fail++;
      $display("FAIL start_collision: got sv=%b cout=%b sum=%0d required sv=1 sum=2",
               bus.sum_valid, bus.cout, bus.sum);
    end
    tick();
    // Bits while IDLE must be ignored.
    sv0 = sv_cnt;
    for (int i = 0; i < 2 * W; i++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit = 1'($urandom_range(0, 1));
      bus.b_bit = 1'($urandom_range(0, 1));
      tick();
    end
    bus.bit_valid = 1'b0;
    tick();
    n_tests++;
    if (sv_cnt != sv0 || bus.busy !== 1'b0 || {bus.cout, bus.sum} !== 5'd2) begin
      n_fail++;
      $display("FAIL idle_bits: got pulses=%0d busy=%b cout=%b sum=%0d required 0 0 0 2",
               sv_cnt - sv0, bus.busy, bus.cout, bus.sum);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   e;
    int           sv0;
    for (int k = 0; k < 24; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom_range(0, 1));
      e = ref_res(a, b, c);
      sv0 = sv_cnt;
      do_start(c);
      send_bits(a, b, 0, W, $urandom_range(0, 2));
      n_tests++;
      if ({bus.sum_valid, bus.cout, bus.sum} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL random_%0d: A=%0d B=%0d cin=%b got sv=%b {cout,sum}=%0d required sv=1 %0d",
                 k, a, b, c, bus.sum_valid, {bus.cout, bus.sum}, e);
      end
`ifdef OVF_DETECT_EN
      n_tests++;
      if (bus.ovf !== ref_ovf(a, b, c)) begin
        n_fail++;
        $display("FAIL random_ovf_%0d: A=%0d B=%0d cin=%b got %b required %b",
                 k, a, b, c, bus.ovf, ref_ovf(a, b, c));
      end
`endif
      for (int g = 0; g <= int'($urandom_range(1, 3)); g++) tick();
      n_tests++;
      if (sv_cnt - sv0 != 1 || {bus.cout, bus.sum} !== e) begin
        n_fail++;
        $display("FAIL random_hold_%0d: got pulses=%0d {cout,sum}=%0d required 1 %0d",
                 k, sv_cnt - sv0, {bus.cout, bus.sum}, e);
      end
    end
  endtask

`ifdef OVF_DETECT_EN
  task automatic test_ovf();
    do_start(1'b0);
    send_bits(4'd7, 4'd1, 0, W, 0);
    n_tests++;
    if ({bus.sum_valid, bus.ovf, bus.cout, bus.sum} !== {1'b1, 1'b1, 5'd8}) begin
      n_fail++;
      $display("FAIL ovf_7_1: got sv=%b ovf=%b cout=%b sum=%0d required 1 1 0 8",
               bus.sum_valid, bus.ovf, bus.cout, bus.sum);
    end
    tick();
    do_start(1'b0);
    send_bits(4'd15, 4'd15, 0, W, 1);
    n_tests++;
    if ({bus.sum_valid, bus.ovf, bus.cout, bus.sum} !== {1'b1, 1'b0, 5'd30}) begin
      n_fail++;
      $display("FAIL ovf_15_15: got sv=%b ovf=%b cout=%b sum=%0d required 1 0 1 14",
               bus.sum_valid, bus.ovf, bus.cout, bus.sum);
    end
    tick();
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail = 0;
    sv_cnt = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cin = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_gaps();
    test_restart();
    test_reset_abort();
    test_start_collision();
`ifdef OVF_DETECT_EN
    test_ovf();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_sipo.md
Name: serial_adder_sipo

Overview:
- Bit-serial adder with serial-in/parallel-out result register.
- Sits directly downstream of the two 4-bit parallel-to-serial operand shifters.
- Consumes one LSB-first bit of operand A and one of operand B per valid cycle, and keeps a running carry in a flip-flop.
- After WIDTH bits, presents the parallel sum and carry-out with a one-cycle valid pulse.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range is 2 or greater.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new word; samples cin and clears the bit counter.
- cin  input  1  initial carry, sampled only in the cycle start is high.
- bit_valid  input  1  a_bit and b_bit are valid this cycle.
- a_bit  input  1  serial operand A, LSB first.
- b_bit  input  1  serial operand B, LSB first.
- sum  output  WIDTH  registered parallel sum; held until the next completed word.
- cout  output  1  registered carry-out of the completed word.
- sum_valid  output  1  one-cycle pulse when sum and cout update.
- busy  output  1  high while a word is being accumulated.
- ovf  output  1  signed overflow; present only with OVF_DETECT_EN.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - sum = 0, cout = 0, sum_valid = 0, busy = 0, ovf = 0.
  - Internal carry = 0, bit counter = 0, shift register = 0, state = IDLE.
- Reset mid-word: aborts the word; no sum_valid is produced.
- States: IDLE and RUN.
- IDLE:
  - bit_valid is ignored.
  - start=1: carry <= cin, count <= 0, shift register <= 0, go to RUN, busy=1 from the next cycle.
- RUN, cycle with bit_valid=1:
  - s = a_bit ^ b_bit ^ carry.
  - carry <= (a_bit & b_bit) | (carry & (a_bit ^ b_bit)).
  - Shift register shifts right with s entering at bit WIDTH-1, so after WIDTH shifts bit 0 holds the LSB.
  - count increments.
- RUN, cycle with bit_valid=0: all state holds; gaps of any length are allowed.
- Last bit (bit_valid=1 and count == WIDTH-1):
  - Next cycle: sum <= shifted register including s, cout <= new carry, sum_valid=1 for exactly one cycle.
  - State returns to IDLE, busy=0.
- Latency: sum_valid is asserted one cycle after the last bit is accepted.
- start in the same cycle as bit_valid, in IDLE or RUN: start wins; the bit is discarded. The first bit is accepted no earlier than the cycle after start.
- start while in RUN (restart): current word is abandoned with no sum_valid; carry <= cin, count <= 0, shift register <= 0; state stays RUN.
- start in the cycle that accepts the last bit: start wins; that word is abandoned and no sum_valid is produced.
- sum and cout hold their last completed values indefinitely.
- Arithmetic: result is {cout, sum} = A + B + cin, modulo 2^(WIDTH+1).
- Bit counter width: $clog2(WIDTH).

Optional Feature:
- Macro: OVF_DETECT_EN.
- Defined:
  - Port ovf exists.
  - The carry into the MSB is captured when bit WIDTH-1 is processed.
  - ovf <= (carry into MSB) ^ (carry out of MSB), registered in the same cycle as sum and cout, so it is valid with sum_valid and held with sum.
  - Reset value 0.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with cin=0; serial A=5 (bits 1,0,1,0), B=3 (bits 1,1,0,0) on 4 consecutive cycles -> one cycle after the 4th bit: sum=8, cout=0, sum_valid high for one cycle, busy low.
- start with cin=1; A=15, B=1 -> sum=1, cout=1. Then start with cin=1; A=0, B=0 -> sum=1, cout=0.
- A=9, B=6, cin=0 with bit_valid low for 2 cycles between each bit -> sum=15, cout=0. sum_valid pulses once, exactly one cycle after the 4th valid bit; busy stays high through the gaps.
- Restart and reset aborts:
  - After 2 bits of a word, assert start with cin=0, then send A=2, B=2 -> sum=4, cout=0; exactly one sum_valid total.
  - After 3 bits of a word, assert reset -> no sum_valid; sum=0, cout=0, busy=0.
- start asserted together with bit_valid=1 and a_bit=b_bit=1 -> that bit is discarded. A following A=1, B=1, cin=0 word -> sum=2. Also, bit_valid pulses while IDLE have no effect on sum.
- With OVF_DETECT_EN defined: A=7, B=1 -> sum=8, cout=0, ovf=1. A=15, B=15 -> sum=14, cout=1, ovf=0.
